audio_ctrl_sched: RTL

Sequencer and arbiter for the 8-bit audio codec control word. It owns the register that drives the codec control pins and runs a timed power-up sequence after reset. It then shares the word between the CPU (Avalon-MM slave, 2-bit word address) and one hardware requester, using round-robin arbitration. After every update it enforces a minimum guard interval before the next one. It sits between the Avalon interconnect and the codec pins, in the same slot as the plain output PIO.

---
 rtl/audio_ctrl_pkg.sv | 28 ++
 rtl/audio_ctrl_rr_arb.sv | 18 +
 rtl/audio_ctrl_sched.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/audio_ctrl_pkg.sv
// Shared types and constants for the audio codec control-word sequencer.
package audio_ctrl_pkg;

    typedef enum logic [1:0] {
        StInit  = 2'd0,
        StIdle  = 2'd1,
        StGuard = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_WORD = 2'd0;
    localparam logic [1:0] ADDR_SET  = 2'd1;
    localparam logic [1:0] ADDR_CLR  = 2'd2;
    localparam logic [1:0] ADDR_STAT = 2'd3;

    localparam int unsigned STAT_BUSY     = 0;
    localparam int unsigned STAT_CPU_PEND = 1;
    localparam int unsigned STAT_HW_REQ   = 2;
    localparam int unsigned STAT_OVERRUN  = 3;
    localparam int unsigned STAT_STATE_LO = 4;
    localparam int unsigned STAT_LAST_HW  = 6;

    function automatic logic [7:0] masked_merge(input logic [7:0] cur,
                                                input logic [7:0] data,
                                                input logic [7:0] mask);
        return (cur & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/audio_ctrl_rr_arb.sv
// Two-way round-robin arbiter: req[0] is the CPU slot, req[1] the hardware requester.
module audio_ctrl_rr_arb
    import audio_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_hw,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        // On a tie, the side that was not served last time wins.
        if (req == 2'b11) begin
            gnt = last_hw ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/audio_ctrl_sched.sv
// Codec control-word owner: power-up sequence, CPU/HW round-robin updates, guard interval.
// Define AUDIO_CTRL_INIT_SEQ_EN to enable the INIT power-up sequence.
module audio_ctrl_sched
    import audio_ctrl_pkg::*;
#(
    parameter logic [7:0]  INIT_WORD    = 8'h03,
    parameter int unsigned INIT_CYCLES  = 16,
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        hw_req,
    input  logic [7:0]  hw_data,
    input  logic [7:0]  hw_mask,
    output logic        hw_grant,
    output logic [7:0]  out_port
);

    localparam int unsigned MAX_CYCLES = (INIT_CYCLES > GUARD_CYCLES) ? INIT_CYCLES : GUARD_CYCLES;
    localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

    state_e       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]   out_q, out_d;
    logic         grant_q, grant_d;
    logic         last_hw_q, last_hw_d;
    logic         pend_q, pend_d;
    logic [7:0]   pdata_q, pdata_d;
    logic [7:0]   pmask_q, pmask_d;
    logic         ovr_q, ovr_d;
    logic         consume;
    logic         wr;
    logic         busy;
    logic [1:0]   gnt;

    logic unused_bits;
`ifdef AUDIO_CTRL_INIT_SEQ_EN
    assign unused_bits = ^writedata[31:8];
`else
    assign unused_bits = ^{writedata[31:8], INIT_WORD};
`endif

    assign wr   = chipselect & ~write_n;
    assign busy = (state_q != StIdle);

    audio_ctrl_rr_arb u_arb (
        .req     ({hw_req, pend_q}),
        .last_hw (last_hw_q),
        .gnt     (gnt)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        grant_d   = 1'b0;
        last_hw_d = last_hw_q;
        consume   = 1'b0;
        unique case (state_q)
`ifdef AUDIO_CTRL_INIT_SEQ_EN
            StInit: begin
                if (cnt_q == '0) begin
                    out_d   = INIT_WORD;
                    state_d = StGuard;
                    cnt_d   = CW'(GUARD_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            StIdle: begin
                if (gnt[0]) begin
                    out_d     = masked_merge(out_q, pdata_q, pmask_q);
                    consume   = 1'b1;
                    last_hw_d = 1'b0;
                    state_d   = StGuard;
                    cnt_d     = CW'(GUARD_CYCLES - 1);
                end else if (gnt[1]) begin
                    out_d     = masked_merge(out_q, hw_data, hw_mask);
                    grant_d   = 1'b1;
                    last_hw_d = 1'b1;
                    state_d   = StGuard;
                    cnt_d     = CW'(GUARD_CYCLES - 1);
                end
            end
            StGuard: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A write landing in the consume cycle becomes the next entry rather than an overrun.
    always_comb begin
        pend_d  = pend_q & ~consume;
        pdata_d = pdata_q;
        pmask_d = pmask_q;
        ovr_d   = ovr_q;
        if (wr) begin
            unique case (address)
                ADDR_WORD: begin
                    pdata_d = writedata[7:0];
                    pmask_d = 8'hFF;
                end
                ADDR_SET: begin
                    pdata_d = 8'hFF;
                    pmask_d = writedata[7:0];
                end
                ADDR_CLR: begin
                    pdata_d = 8'h00;
                    pmask_d = writedata[7:0];
                end
                default: ovr_d = 1'b0;
            endcase
            if (address != ADDR_STAT) begin
                pend_d = 1'b1;
                if (pend_q && !consume) begin
                    ovr_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
`ifdef AUDIO_CTRL_INIT_SEQ_EN
            state_q <= StInit;
            cnt_q   <= CW'(INIT_CYCLES - 1);
`else
            state_q <= StIdle;
            cnt_q   <= '0;
`endif
            out_q     <= 8'h00;
            grant_q   <= 1'b0;
            last_hw_q <= 1'b1;
            pend_q    <= 1'b0;
            pdata_q   <= 8'h00;
            pmask_q   <= 8'h00;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            grant_q   <= grant_d;
            last_hw_q <= last_hw_d;
            pend_q    <= pend_d;
            pdata_q   <= pdata_d;
            pmask_q   <= pmask_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        readdata = '0;
        unique case (address)
            ADDR_WORD: readdata[7:0] = out_q;
            ADDR_SET:  readdata[7:0] = pdata_q;
            ADDR_CLR:  readdata[7:0] = pmask_q;
            default: begin
                readdata[STAT_BUSY]            = busy;
                readdata[STAT_CPU_PEND]        = pend_q;
                readdata[STAT_HW_REQ]          = hw_req;
                readdata[STAT_OVERRUN]         = ovr_q;
                readdata[STAT_STATE_LO +: 2]   = state_q;
                readdata[STAT_LAST_HW]         = last_hw_q;
            end
        endcase
    end

    assign out_port = out_q;
    assign hw_grant = grant_q;

endmodule
